// File: rtl/hub75_scan_ctrl.sv
// HUB75 panel scan driver: shifts one BCM bit-plane per pass from a dual-half
// framebuffer, latches it, then lights the row for BASE_TIME<<plane cycles.
module hub75_scan_ctrl #(
  parameter int COLS       = 64,
  parameter int ROW_ADDR_W = 4,
  parameter int COLOR_BITS = 1,
  parameter int BASE_TIME  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  output logic                      pix_rd_en,
  output logic [$clog2(COLS)-1:0]   pix_col,
  output logic [ROW_ADDR_W-1:0]     pix_row,
  input  logic [3*COLOR_BITS-1:0]   pix_data0,
  input  logic [3*COLOR_BITS-1:0]   pix_data1,
  output logic [ROW_ADDR_W-1:0]     row_addr,
  output logic                      R0,
  output logic                      G0,
  output logic                      B0,
  output logic                      R1,
  output logic                      G1,
  output logic                      B1,
  output logic                      sclk,
  output logic                      LAT,
  output logic                      OE,
  output logic                      frame_start
);
  localparam int COL_W   = $clog2(COLS);
  localparam int PLANE_W = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int CNT_W   = $clog2(BASE_TIME << (COLOR_BITS - 1)) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PREFETCH, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY
  } state_e;

  state_e                state_q, state_d;
  logic                  phase_q, phase_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_ADDR_W-1:0] row_q, row_d;
  logic [PLANE_W-1:0]    plane_q, plane_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  rd_en_q, rd_en_d;
  logic [COL_W-1:0]      pix_col_q, pix_col_d;
  logic [ROW_ADDR_W-1:0] pix_row_q, pix_row_d;
  logic [ROW_ADDR_W-1:0] row_addr_q, row_addr_d;
  logic [5:0]            rgb_q, rgb_d;
  logic                  sclk_q, sclk_d;
  logic                  lat_q, lat_d;
  logic                  oe_q, oe_d;
  logic                  fs_q, fs_d;

  always_comb begin
    int unsigned pidx;
    pidx       = 32'(plane_q);
    state_d    = state_q;
    phase_d    = phase_q;
    col_d      = col_q;
    row_d      = row_q;
    plane_d    = plane_q;
    cnt_d      = cnt_q;
    rd_en_d    = 1'b0;
    pix_col_d  = pix_col_q;
    pix_row_d  = pix_row_q;
    row_addr_d = row_addr_q;
    rgb_d      = rgb_q;
    sclk_d     = 1'b0;
    lat_d      = 1'b0;
    oe_d       = 1'b1;
    fs_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d   = S_PREFETCH;
          rd_en_d   = 1'b1;
          pix_col_d = '0;
          pix_row_d = row_q;
          fs_d      = (row_q == '0) && (plane_q == '0);
        end
      end
      S_PREFETCH: begin
        state_d = S_SHIFT;
        phase_d = 1'b0;
        col_d   = '0;
      end
      S_SHIFT: begin
        // Data for column k arrives during ph0 and is presented with the sclk rise,
        // while the read for column k+1 is issued in the same ph1 cycle.
        if (!phase_q) begin
          phase_d = 1'b1;
          sclk_d  = 1'b1;
          rgb_d   = {pix_data0[2*COLOR_BITS + pidx], pix_data0[COLOR_BITS + pidx],
                     pix_data0[pidx],
                     pix_data1[2*COLOR_BITS + pidx], pix_data1[COLOR_BITS + pidx],
                     pix_data1[pidx]};
          if (col_q != COL_W'(COLS - 1)) begin
            rd_en_d   = 1'b1;
            pix_col_d = col_q + 1'b1;
          end
        end else begin
          phase_d = 1'b0;
          if (col_q == COL_W'(COLS - 1)) begin
            state_d    = S_BLANK;
            row_addr_d = row_q;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_BLANK: begin
        state_d = S_LATCH;
        lat_d   = 1'b1;
      end
      S_LATCH: begin
        state_d = S_DISPLAY;
        oe_d    = 1'b0;
        cnt_d   = CNT_W'((BASE_TIME << plane_q) - 1);
      end
      S_DISPLAY: begin
        if (cnt_q == '0) begin
          if (plane_q == PLANE_W'(COLOR_BITS - 1)) begin
            plane_d = '0;
            row_d   = row_q + 1'b1;
          end else begin
            plane_d = plane_q + 1'b1;
          end
          if (enable) begin
            state_d   = S_PREFETCH;
            rd_en_d   = 1'b1;
            pix_col_d = '0;
            pix_row_d = row_d;
            fs_d      = (row_d == '0) && (plane_d == '0);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          oe_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      plane_q    <= '0;
      cnt_q      <= '0;
      rd_en_q    <= 1'b0;
      pix_col_q  <= '0;
      pix_row_q  <= '0;
      row_addr_q <= '0;
      rgb_q      <= '0;
      sclk_q     <= 1'b0;
      lat_q      <= 1'b0;
      oe_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      col_q      <= col_d;
      row_q      <= row_d;
      plane_q    <= plane_d;
      cnt_q      <= cnt_d;
      rd_en_q    <= rd_en_d;
      pix_col_q  <= pix_col_d;
      pix_row_q  <= pix_row_d;
      row_addr_q <= row_addr_d;
      rgb_q      <= rgb_d;
      sclk_q     <= sclk_d;
      lat_q      <= lat_d;
      oe_q       <= oe_d;
      fs_q       <= fs_d;
    end
  end

  assign pix_rd_en   = rd_en_q;
  assign pix_col     = pix_col_q;
  assign pix_row     = pix_row_q;
  assign row_addr    = row_addr_q;
  assign {R0, G0, B0, R1, G1, B1} = rgb_q;
  assign sclk        = sclk_q;
  assign LAT         = lat_q;
  assign OE          = oe_q;
  assign frame_start = fs_q;
endmodule
